// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO used for the in-flight PC queue and the instruction buffer.
// Head entry is read straight from the storage registers.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Clear drops every entry but leaves storage contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns the fetch PC, issues in-order imem reads under a credit limit,
// buffers returned words for decode and flushes on branch/jump redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned   N          = 32,
  parameter logic [N-1:0]  RESET_PC   = N'(DEFAULT_RESET_PC),
  parameter int unsigned   FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] pc_cur,
  input  logic [N-1:0] pc_next,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [N-1:0] imem_resp_data,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [N-1:0] dec_instr,
  output logic [N-1:0] dec_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e   state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  inflight, occ;
  logic [N-1:0]   pcq_head;
  logic [2*N-1:0] ibuf_head;
  logic           pcq_full, pcq_empty, ibuf_full, ibuf_empty;
  logic           can_issue, req_fire, resp_drop, ibuf_push, dec_fire;

  // Buffered plus outstanding words may never exceed the buffer capacity.
  assign can_issue = (SW'(occ) + SW'(inflight)) < SW'(FIFO_DEPTH);

  assign imem_req_valid = (state_q == FETCH_RUN) && !redirect && can_issue;
  assign imem_req_addr  = pc_q;
  assign pc_cur         = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = imem_resp_valid && (redirect || (drop_q != '0));
  assign ibuf_push      = imem_resp_valid && !resp_drop;
  assign dec_valid      = !ibuf_empty;
  assign dec_fire       = dec_valid && dec_ready;
  assign dec_instr      = ibuf_head[2*N-1:N];
  assign dec_pc         = ibuf_head[N-1:0];

  fetch_fifo #(.WIDTH(N), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (imem_resp_valid),
    .clear (1'b0),
    .din   (pc_q),
    .dout  (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (inflight)
  );

  fetch_fifo #(.WIDTH(2*N), .DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ibuf_push),
    .pop   (dec_fire),
    .clear (redirect),
    .din   ({imem_resp_data, pcq_head}),
    .dout  (ibuf_head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (occ)
  );

  // Next state, next fetch PC and stale-response drop count.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (req_fire) pc_d = pc_next;
    unique case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (redirect) begin
          drop_d = inflight + CW'(req_fire) - CW'(imem_resp_valid);
          if (drop_d != '0) state_d = FETCH_FLUSH;
        end
      end
      FETCH_FLUSH: begin
        if (drop_d == '0) state_d = FETCH_RUN;
      end
      default: state_d = FETCH_BOOT;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> !pcq_empty);
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && pcq_full) && !(ibuf_push && ibuf_full));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: imem model with configurable latency, decode-order reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur, pc_next;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        dec_valid, dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;

  instr_fetch #(.N(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  // Stand-in for program_counter: sequential increment.
  assign pc_next = pc_cur + 32'd4;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] obs_pc[$], obs_instr[$], exp_pc[$];
  logic [31:0] model_pc;
  int          cyc = 0, last_due = 0;
  int          n_cmp = 0, n_err = 0;
  logic        p_redir, p_rdy, p_dr;
  logic [31:0] p_rpc;
  int          p_lat;
  logic        obs_req_valid, obs_dec_valid, obs_resp;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic step();
    int due;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    obs_resp        = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(pend[0].addr);
      void'(pend.pop_front());
      obs_resp = 1'b1;
    end
    redirect       = p_redir;
    redirect_pc    = p_rpc;
    imem_req_ready = p_rdy;
    dec_ready      = p_dr;
    #1;
    obs_req_valid = imem_req_valid;
    obs_dec_valid = dec_valid;
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + p_lat;
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{addr: imem_req_addr, due: due});
      last_due = due;
      req_log.push_back(imem_req_addr);
    end
    if (dec_valid && dec_ready) begin
      obs_pc.push_back(dec_pc);
      obs_instr.push_back(dec_instr);
      exp_pc.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    if (redirect) model_pc = redirect_pc;
    p_redir = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; dec_ready = 1'b0;
    p_redir = 1'b0; p_rpc = '0; p_rdy = 1'b1; p_dr = 1'b1; p_lat = 1;
    pend.delete(); req_log.delete();
    obs_pc.delete(); obs_instr.delete(); exp_pc.delete();
    model_pc = 32'h0; last_due = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (pc_cur !== 32'h0 || imem_req_valid !== 1'b0 || dec_valid !== 1'b0 ||
        dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_values: pc_cur=%h req_valid=%b dec_valid=%b instr=%h pc=%h, want 0s",
               pc_cur, imem_req_valid, dec_valid, dec_instr, dec_pc);
    end
    do_reset();
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL boot_no_req: req_valid=%b want 0", imem_req_valid);
    end
    step();
    n_cmp++;
    if (obs_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h want 1/00000000", obs_req_valid, imem_req_addr);
    end
    repeat (6) step();
    n_cmp++;
    if (obs_dec_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_stream: dec_valid=%b want 1", obs_dec_valid);
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_cur !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: dec_valid=%b req_valid=%b pc_cur=%h want 0/0/0",
               dec_valid, imem_req_valid, pc_cur);
    end
  endtask

  task automatic test_stream();
    int mid;
    do_reset();
    repeat (20) step();
    mid = obs_pc.size();
    repeat (20) step();
    n_cmp++;
    if (obs_pc.size() - mid != 20) begin
      n_err++; $display("FAIL stream_rate: %0d decodes in 20 cycles want 20", obs_pc.size() - mid);
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++;
      if (obs_pc[i] !== exp_pc[i] || obs_instr[i] !== word(exp_pc[i])) begin
        n_err++;
        $display("FAIL stream[%0d]: pc=%h instr=%h want pc=%h instr=%h",
                 i, obs_pc[i], obs_instr[i], exp_pc[i], word(exp_pc[i]));
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] want;
    do_reset();
    p_dr = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (req_log.size() != 4 || obs_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credit: %0d requests req_valid=%b want 4/0", req_log.size(), obs_req_valid);
    end
    p_dr = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      want = 32'(i * 4);
      n_cmp++;
      if (obs_pc.size() <= i || obs_pc[i] !== want) begin
        n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i,
                          (obs_pc.size() > i) ? obs_pc[i] : 32'hx, want);
      end
    end
    n_cmp++;
    if (req_log.size() < 5 || req_log[4] !== 32'h10) begin
      n_err++; $display("FAIL bp_resume: next request not 00000010 (%0d logged)", req_log.size());
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++;
      if (obs_pc[i] !== exp_pc[i] || obs_instr[i] !== word(exp_pc[i])) begin
        n_err++;
        $display("FAIL bp_stream[%0d]: pc=%h instr=%h want pc=%h", i, obs_pc[i], obs_instr[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    p_lat = 3;
    repeat (2) step();
    n_cmp++;
    if (req_log.size() != 2 || obs_pc.size() != 0) begin
      n_err++;
      $display("FAIL redir_setup: %0d reqs %0d decodes want 2/0", req_log.size(), obs_pc.size());
    end
    p_rdy = 1'b0; p_redir = 1'b1; p_rpc = 32'h100;
    step();
    p_rdy = 1'b1;
    step();
    n_cmp++;
    if (obs_dec_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_dec_quiet: dec_valid=%b want 0", obs_dec_valid);
    end
    repeat (20) step();
    n_cmp++;
    if (req_log.size() < 3 || req_log[2] !== 32'h100) begin
      n_err++; $display("FAIL redir_next_req: first post-redirect request not 00000100");
    end
    n_cmp++;
    if (obs_pc.size() == 0 || obs_pc[0] !== 32'h100) begin
      n_err++; $display("FAIL redir_first_dec: got %h want 00000100",
                        (obs_pc.size() != 0) ? obs_pc[0] : 32'hx);
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++;
      if (obs_pc[i] !== exp_pc[i] || obs_instr[i] !== word(exp_pc[i])) begin
        n_err++;
        $display("FAIL redir_stream[%0d]: pc=%h instr=%h want pc=%h", i, obs_pc[i], obs_instr[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_coincident();
    int n_before;
    int budget = 50;
    do_reset();
    p_lat = 2;
    while (budget > 0 && !(req_log.size() != 0 && req_log[$] == 32'h20)) begin
      step();
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_err++; $display("FAIL coinc_setup: request 00000020 never accepted within 50 cycles");
    end
    p_redir = 1'b1; p_rpc = 32'h200;
    step();
    n_before = obs_pc.size();
    n_cmp++;
    if (obs_resp !== 1'b1 || obs_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL coinc_cycle: resp=%b req_valid=%b want 1/0", obs_resp, obs_req_valid);
    end
    repeat (20) step();
    n_cmp++;
    if (obs_pc.size() <= n_before || obs_pc[n_before] !== 32'h200) begin
      n_err++; $display("FAIL coinc_first_dec: got %h want 00000200",
                        (obs_pc.size() > n_before) ? obs_pc[n_before] : 32'hx);
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++;
      if (obs_pc[i] !== exp_pc[i] || obs_instr[i] !== word(exp_pc[i])) begin
        n_err++;
        $display("FAIL coinc_stream[%0d]: pc=%h instr=%h want pc=%h", i, obs_pc[i], obs_instr[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] stall_addr;
    int          n_log;
    do_reset();
    repeat (8) step();
    stall_addr = req_log[$] + 32'd4;
    n_log = req_log.size();
    p_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs_req_valid !== 1'b1 || imem_req_addr !== stall_addr || pc_cur !== stall_addr) begin
        n_err++;
        $display("FAIL stall[%0d]: valid=%b addr=%h pc_cur=%h want 1/%h/%h",
                 i, obs_req_valid, imem_req_addr, pc_cur, stall_addr, stall_addr);
      end
    end
    p_rdy = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (req_log.size() <= n_log || req_log[n_log] !== stall_addr) begin
      n_err++; $display("FAIL stall_resume: next accepted request not %h", stall_addr);
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++;
      if (obs_pc[i] !== exp_pc[i] || obs_instr[i] !== word(exp_pc[i])) begin
        n_err++;
        $display("FAIL stall_stream[%0d]: pc=%h instr=%h want pc=%h", i, obs_pc[i], obs_instr[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] wrap_seq [3];
    wrap_seq[0] = 32'hFFFF_FFF8; wrap_seq[1] = 32'hFFFF_FFFC; wrap_seq[2] = 32'h0;
    do_reset();
    p_redir = 1'b1; p_rpc = 32'hFFFF_FFF8;
    step();
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_pc.size() <= i || obs_pc[i] !== wrap_seq[i]) begin
        n_err++; $display("FAIL wrap[%0d]: got %h want %h", i,
                          (obs_pc.size() > i) ? obs_pc[i] : 32'hx, wrap_seq[i]);
      end
    end
    for (int i = 0; i < 600; i++) begin
      p_rdy = ($urandom_range(0, 3) != 0);
      p_dr  = ($urandom_range(0, 4) != 0);
      p_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) begin
        p_redir = 1'b1;
        p_rpc   = $urandom & 32'hFFFF_FFFC;
      end
      step();
    end
    n_cmp++;
    if (obs_pc.size() < 100) begin
      n_err++; $display("FAIL rand_progress: %0d decodes want >=100", obs_pc.size());
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++;
      if (obs_pc[i] !== exp_pc[i] || obs_instr[i] !== word(exp_pc[i])) begin
        n_err++;
        $display("FAIL rand_stream[%0d]: pc=%h instr=%h want pc=%h", i, obs_pc[i], obs_instr[i], exp_pc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect_inflight();
    test_coincident();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
